// File: rtl/mem_rd_arbiter_pkg.sv
// Shared constants for the MEM burst-read arbiter: FSM state encoding,
// master IDs and the grant-selection helper.
package mem_rd_arbiter_pkg;

    localparam int unsigned ST_W   = 2;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned SIZE_W = 3;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_I = 2'd1;
    localparam logic [1:0] GNT_D = 2'd2;

    localparam logic MID_I = 1'b0;
    localparam logic MID_D = 1'b1;

    // Pick the next grant from the two requests; prefer_d breaks ties.
    function automatic logic [1:0] arb_pick(
        input logic i_req,
        input logic d_req,
        input logic prefer_d
    );
        logic [1:0] pick;
        pick = IDLE;
        if (i_req && d_req) begin
            pick = prefer_d ? GNT_D : GNT_I;
        end else if (d_req) begin
            pick = GNT_D;
        end else if (i_req) begin
            pick = GNT_I;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_rd_arbiter.sv
// Shares MEM's burst-read port between icache and dcache refills, one grant per burst.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin tie-break (default: dcache priority).
module mem_rd_arbiter
    import mem_rd_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rvalid,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    input  logic [SIZE_W-1:0]     i_rsize,
    input  logic [CNT_W-1:0]      i_rlen,
    output logic                  i_rready,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_rlast,
    input  logic                  d_rvalid,
    input  logic [ADDR_WIDTH-1:0] d_raddr,
    input  logic [SIZE_W-1:0]     d_rsize,
    input  logic [CNT_W-1:0]      d_rlen,
    output logic                  d_rready,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_rlast,
    output logic                  m_rvalid,
    output logic [ADDR_WIDTH-1:0] m_raddr,
    output logic [SIZE_W-1:0]     m_rsize,
    output logic [CNT_W-1:0]      m_rlen,
    input  logic                  m_rready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic                  m_rlast,
    output logic                  arb_err
);

    logic [ST_W-1:0]  state_q,    state_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             arb_err_q,  arb_err_d;
    logic             prefer_d;
    logic             granted;
    logic             final_beat;
    logic [CNT_W-1:0] gnt_rlen;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_gnt_q, last_gnt_d;

    // Tie goes to whichever master was not served most recently.
    assign prefer_d = (last_gnt_q == MID_I);

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (state_d == GNT_I) begin
            last_gnt_d = MID_I;
        end else if (state_d == GNT_D) begin
            last_gnt_d = MID_D;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q <= MID_I;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`else
    assign prefer_d = 1'b1;
`endif

    assign granted    = (state_q == GNT_I) || (state_q == GNT_D);
    assign final_beat = granted && m_rready && m_rlast;
    assign gnt_rlen   = (state_q == GNT_D) ? d_rlen : i_rlen;

    // Next-state: grant is held for the whole burst; on the final beat the
    // completing master is masked so a pending peer is granted with no bubble.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                state_d = arb_pick(i_rvalid, d_rvalid, prefer_d);
            end
            GNT_I: begin
                if (final_beat) begin
                    state_d = arb_pick(1'b0, d_rvalid, prefer_d);
                end
            end
            GNT_D: begin
                if (final_beat) begin
                    state_d = arb_pick(i_rvalid, 1'b0, prefer_d);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Beat counter and sticky length-mismatch flag; beats outside a grant are ignored.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        arb_err_d  = arb_err_q;
        if (granted && m_rready) begin
            if (m_rlast) begin
                beat_cnt_d = '0;
                if (beat_cnt_q != gnt_rlen) begin
                    arb_err_d = 1'b1;
                end
            end else begin
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            arb_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            arb_err_q  <= arb_err_d;
        end
    end

    // Request and response steering follow the registered grant.
    always_comb begin
        m_rvalid = 1'b0;
        m_raddr  = '0;
        m_rsize  = '0;
        m_rlen   = '0;
        i_rready = 1'b0;
        i_rdata  = '0;
        i_rlast  = 1'b0;
        d_rready = 1'b0;
        d_rdata  = '0;
        d_rlast  = 1'b0;
        case (state_q)
            GNT_I: begin
                m_rvalid = i_rvalid;
                m_raddr  = i_raddr;
                m_rsize  = i_rsize;
                m_rlen   = i_rlen;
                i_rready = m_rready;
                i_rdata  = m_rdata;
                i_rlast  = m_rlast;
            end
            GNT_D: begin
                m_rvalid = d_rvalid;
                m_raddr  = d_raddr;
                m_rsize  = d_rsize;
                m_rlen   = d_rlen;
                d_rready = m_rready;
                d_rdata  = m_rdata;
                d_rlast  = m_rlast;
            end
            default: begin
            end
        endcase
    end

    assign arb_err = arb_err_q;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter; the bench itself plays both caches and MEM.
// Tie-break expectations follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_rvalid, d_rvalid;
    logic [31:0] i_raddr, d_raddr;
    logic [2:0]  i_rsize, d_rsize;
    logic [7:0]  i_rlen, d_rlen;
    logic        i_rready, d_rready, i_rlast, d_rlast;
    logic [31:0] i_rdata, d_rdata;
    logic        m_rvalid;
    logic [31:0] m_raddr;
    logic [2:0]  m_rsize;
    logic [7:0]  m_rlen;
    logic        m_rready, m_rlast;
    logic [31:0] m_rdata;
    logic        arb_err;

    int n_checks = 0;
    int n_err    = 0;

    mem_rd_arbiter dut (
        .clk(clk), .rst(rst),
        .i_rvalid(i_rvalid), .i_raddr(i_raddr), .i_rsize(i_rsize), .i_rlen(i_rlen),
        .i_rready(i_rready), .i_rdata(i_rdata), .i_rlast(i_rlast),
        .d_rvalid(d_rvalid), .d_raddr(d_raddr), .d_rsize(d_rsize), .d_rlen(d_rlen),
        .d_rready(d_rready), .d_rdata(d_rdata), .d_rlast(d_rlast),
        .m_rvalid(m_rvalid), .m_raddr(m_raddr), .m_rsize(m_rsize), .m_rlen(m_rlen),
        .m_rready(m_rready), .m_rdata(m_rdata), .m_rlast(m_rlast),
        .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic all_zero(input string tag);
        chk1({tag, "_m_rvalid"}, m_rvalid, 1'b0);
        chkw({tag, "_m_raddr"},  m_raddr,  32'h0);
        chk1({tag, "_i_rready"}, i_rready, 1'b0);
        chk1({tag, "_d_rready"}, d_rready, 1'b0);
        chkw({tag, "_d_rdata"},  d_rdata,  32'h0);
        chk1({tag, "_d_rlast"},  d_rlast,  1'b0);
        chk1({tag, "_arb_err"},  arb_err,  1'b0);
    endtask

    initial begin
        logic [31:0] exp_addr;
        rst = 1'b1;
        i_rvalid = 0; i_raddr = 0; i_rsize = 0; i_rlen = 0;
        d_rvalid = 0; d_raddr = 0; d_rsize = 0; d_rlen = 0;
        m_rready = 0; m_rdata = 0; m_rlast = 0;
        tick(); tick();
        all_zero("por");
        rst = 1'b0;
        tick();

        // Reset asserted in the middle of a dcache burst
        d_rvalid = 1; d_raddr = 32'h200; d_rlen = 8'd3; d_rsize = 3'd2;
        tick();
        #1;
        chk1("t1_gnt_d", m_rvalid, 1'b1);
        chkw("t1_addr", m_raddr, 32'h200);
        m_rready = 1; m_rdata = 32'hD0;
        #1;
        chkw("t1_d_rdata", d_rdata, 32'hD0);
        tick();
        rst = 1'b1;
        #1;
        all_zero("t1_rst");
        d_rvalid = 0; m_rready = 0; m_rdata = 0;
        tick();
        rst = 1'b0;
        tick();

        // icache-only burst of 4 beats
        i_rvalid = 1; i_raddr = 32'h100; i_rlen = 8'd3; i_rsize = 3'd2;
        #1;
        chk1("t2_bubble", m_rvalid, 1'b0);
        tick();
        chkw("t2_addr", m_raddr, 32'h100);
        chkw("t2_rlen", 32'(m_rlen), 32'd3);
        chkw("t2_rsize", 32'(m_rsize), 32'd2);
        for (int b = 0; b < 4; b++) begin
            m_rready = 1; m_rdata = 32'hA0 + 32'(b); m_rlast = (b == 3);
            #1;
            chk1("t2_i_rready", i_rready, 1'b1);
            chkw("t2_i_rdata", i_rdata, 32'hA0 + 32'(b));
            chk1("t2_i_rlast", i_rlast, (b == 3));
            chk1("t2_d_rready", d_rready, 1'b0);
            tick();
        end
        i_rvalid = 0; m_rready = 0; m_rlast = 0;
        #1;
        chk1("t2_idle", m_rvalid, 1'b0);
        chk1("t2_err", arb_err, 1'b0);

        // Simultaneous requests: dcache first, icache chained with no bubble
        i_rvalid = 1; i_raddr = 32'h300; i_rlen = 8'd0;
        d_rvalid = 1; d_raddr = 32'h400; d_rlen = 8'd1;
        tick();
        chkw("t3_first_d", m_raddr, 32'h400);
        m_rready = 1; m_rdata = 32'h11; m_rlast = 0;
        #1;
        chk1("t3_d_beat0", d_rready, 1'b1);
        chk1("t3_i_masked", i_rready, 1'b0);
        tick();
        m_rdata = 32'h22; m_rlast = 1;
        #1;
        chk1("t3_d_rlast", d_rlast, 1'b1);
        chk1("t3_i_rlast0", i_rlast, 1'b0);
        tick();
        d_rvalid = 0;
        #1;
        chk1("t3_no_bubble", m_rvalid, 1'b1);
        chkw("t3_then_i", m_raddr, 32'h300);
        chk1("t3_i_single", i_rlast, 1'b1);
        tick();
        i_rvalid = 0; m_rready = 0; m_rlast = 0;
        #1;
        chk1("t3_idle", m_rvalid, 1'b0);

        // Held simultaneous requests alternate D,I,D,I
        i_rvalid = 1; i_raddr = 32'h500; i_rlen = 8'd0;
        d_rvalid = 1; d_raddr = 32'h600; d_rlen = 8'd0;
        tick();
        for (int g = 0; g < 4; g++) begin
            exp_addr = (g % 2 == 0) ? 32'h600 : 32'h500;
            m_rready = 1; m_rlast = 1; m_rdata = 32'hC0 + 32'(g);
            #1;
            chkw("t4_order", m_raddr, exp_addr);
            if (g == 3) d_rvalid = 0;
            tick();
        end
        i_rvalid = 0; m_rready = 0; m_rlast = 0;
        #1;
        chk1("t4_idle", m_rvalid, 1'b0);

        // After a dcache-only burst, a tie shows the configured policy
        d_rvalid = 1; d_raddr = 32'h700; d_rlen = 8'd0;
        tick();
        m_rready = 1; m_rlast = 1;
        tick();
        d_rvalid = 0; m_rready = 0; m_rlast = 0;
        tick();
        i_rvalid = 1; d_rvalid = 1; d_raddr = 32'h600;
        tick();
`ifdef ARB_ROUND_ROBIN_EN
        chkw("t4_tie_policy", m_raddr, 32'h500);
`else
        chkw("t4_tie_policy", m_raddr, 32'h600);
`endif
        i_rvalid = 0; d_rvalid = 0; m_rready = 1; m_rlast = 1;
        tick();
        m_rready = 0; m_rlast = 0;
        #1;
        chk1("t4_tie_idle", m_rvalid, 1'b0);

        // Stray beat while idle must not count
        m_rready = 1;
        tick();
        m_rready = 0;
        d_rvalid = 1; d_raddr = 32'h800; d_rlen = 8'd1;
        tick();
        m_rready = 1; m_rlast = 0;
        tick();
        m_rlast = 1;
        tick();
        d_rvalid = 0; m_rready = 0; m_rlast = 0;
        #1;
        chk1("t5_idle_beat_ignored", arb_err, 1'b0);

        // rlen=0 dcache burst: single final beat
        d_rvalid = 1; d_raddr = 32'h900; d_rlen = 8'd0;
        tick();
        m_rready = 1; m_rlast = 1; m_rdata = 32'h5A;
        #1;
        chk1("t5_d_rlast", d_rlast, 1'b1);
        chkw("t5_d_rdata", d_rdata, 32'h5A);
        tick();
        d_rvalid = 0; m_rready = 0; m_rlast = 0;
        #1;
        chk1("t5_d_rlast_gone", d_rlast, 1'b0);
        chk1("t5_err", arb_err, 1'b0);

        // Early m_rlast (beat 2 of 4) sets sticky error
        i_rvalid = 1; i_raddr = 32'hA00; i_rlen = 8'd3;
        tick();
        for (int b = 0; b < 3; b++) begin
            m_rready = 1; m_rlast = (b == 2);
            tick();
        end
        i_rvalid = 0; m_rready = 0; m_rlast = 0;
        #1;
        chk1("t6_err_set", arb_err, 1'b1);
        chk1("t6_idle", m_rvalid, 1'b0);
        tick(); tick();
        chk1("t6_err_sticky", arb_err, 1'b1);
        d_rvalid = 1; d_rlen = 8'd0;
        tick();
        m_rready = 1; m_rlast = 1;
        tick();
        d_rvalid = 0; m_rready = 0; m_rlast = 0;
        #1;
        chk1("t6_err_after_good", arb_err, 1'b1);
        rst = 1'b1;
        #1;
        chk1("t6_err_cleared", arb_err, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
